// File: rtl/serialize_word_to_bit_stream_pkg.sv
// Shared types and helpers for the word-to-bit serializer.
package serializer_pkg;

  // Serializer control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Bit-position counter width for a given word width (WIDTH >= 2).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serialize_word_to_bit_stream_if.sv
// Upstream word handshake plus downstream serial bit stream.
interface serialize_word_to_bit_stream_if #(
  parameter int unsigned WIDTH = 8
);

  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             down_valid;
  logic             down_bit;
  logic             down_last;
  logic             busy;

  // Word source / bit sink side.
  modport master (
    output up_valid,
    output up_data,
    input  up_ready,
    input  down_valid,
    input  down_bit,
    input  down_last,
    input  busy
  );

  // Serializer side.
  modport slave (
    input  up_valid,
    input  up_data,
    output up_ready,
    output down_valid,
    output down_bit,
    output down_last,
    output busy
  );

endinterface

// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-to-serial stage: one WIDTH-bit word in, one bit per clock out,
// back-to-back words with no idle cycle between them.
module serialize_word_to_bit_stream
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input logic                           clk,
  input logic                           rst,
  serialize_word_to_bit_stream_if.slave bus
);

  localparam int unsigned   CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             at_last;
  logic             accept;
  logic             out_bit;

  // Final bit of the current word is on the output this cycle.
  assign at_last = (state == SHIFT) && (cnt == LAST_CNT);

  // Ready depends only on state/cnt so a new word can reload on the last bit.
  assign bus.up_ready = !rst && ((state == IDLE) || at_last);
  assign accept       = bus.up_valid && bus.up_ready;

  // Control FSM, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
            sr    <= bus.up_data;
          end
        end
        SHIFT: begin
          if (!at_last) begin
            cnt <= cnt + CW'(1);
            if (MSB_FIRST) begin
              sr <= {sr[WIDTH-2:0], 1'b0};
            end else begin
              sr <= {1'b0, sr[WIDTH-1:1]};
            end
          end else if (accept) begin
            cnt <= '0;
            sr  <= bus.up_data;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output end of the shift register in the selected transmit order.
  assign out_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];

  // Outputs are decodes of the registered state, counter and shift register.
  assign bus.down_valid = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.down_last  = at_last;
  assign bus.down_bit   = (state == SHIFT) ? out_bit : IDLE_BIT;

endmodule

// File: tb/tb_serialize_word_to_bit_stream.sv
// Directed bench: an MSB-first/IDLE_BIT=0 and an LSB-first/IDLE_BIT=1
// serializer fed the same word stream, each checked against its own table.
module tb_serialize_word_to_bit_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_valid = 1'b0;
  logic [7:0] up_data = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serialize_word_to_bit_stream_if #(.WIDTH(8)) m_if ();
  serialize_word_to_bit_stream_if #(.WIDTH(8)) l_if ();

  assign m_if.up_valid = up_valid;
  assign m_if.up_data  = up_data;
  assign l_if.up_valid = up_valid;
  assign l_if.up_data  = up_data;

  serialize_word_to_bit_stream #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut_m (
    .clk(clk), .rst(rst), .bus(m_if)
  );

  serialize_word_to_bit_stream #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) dut_l (
    .clk(clk), .rst(rst), .bus(l_if)
  );

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_m;  // transmit order, first bit in [7]
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One isolated word, checked bit by bit on both serializers, then idle.
  task automatic run_word(input vec_t v);
    @(negedge clk);
    chk("ready_idle_m", 32'(m_if.up_ready), 32'd1);
    chk("ready_idle_l", 32'(l_if.up_ready), 32'd1);
    up_valid = 1'b1;
    up_data  = v.word;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_data  = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("valid_m", 32'(m_if.down_valid), 32'd1);
      chk("busy_m", 32'(m_if.busy), 32'd1);
      chk("bit_m", 32'(m_if.down_bit), 32'(v.exp_m[7-i]));
      chk("last_m", 32'(m_if.down_last), 32'(i == 7));
      chk("ready_m", 32'(m_if.up_ready), 32'(i == 7));
      chk("valid_l", 32'(l_if.down_valid), 32'd1);
      chk("bit_l", 32'(l_if.down_bit), 32'(v.exp_l[7-i]));
      chk("last_l", 32'(l_if.down_last), 32'(i == 7));
    end
    @(negedge clk);
    chk("after_valid_m", 32'(m_if.down_valid), 32'd0);
    chk("after_busy_m", 32'(m_if.busy), 32'd0);
    chk("after_idle_bit_m", 32'(m_if.down_bit), 32'd0);
    chk("after_valid_l", 32'(l_if.down_valid), 32'd0);
    chk("after_idle_bit_l", 32'(l_if.down_bit), 32'd1);
  endtask

  // Two words: w0 accepted from idle, w1 offered from start (raise_at < 0)
  // or raised after bit raise_at of w0. Records 16 cycles of the MSB-first output.
  task automatic run_pair(input logic [7:0] w0, input logic [7:0] w1, input int raise_at,
                          output logic [15:0] bits, output logic [15:0] lasts,
                          output logic [15:0] rdys, output logic [15:0] vals);
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = w0;
    @(posedge clk);
    #1;
    up_data  = w1;
    up_valid = (raise_at < 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bits[15-i]  = m_if.down_bit;
      lasts[15-i] = m_if.down_last;
      rdys[15-i]  = m_if.up_ready;
      vals[15-i]  = m_if.down_valid;
      if (i == raise_at) up_valid = 1'b1;
      if (i == 7) begin
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_data  = 8'h00;
      end
    end
    @(negedge clk);
    chk("pair_end_valid", 32'(m_if.down_valid), 32'd0);
    chk("pair_end_ready", 32'(m_if.up_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    logic [15:0] bits, lasts, rdys, vals;
    logic [5:0]  win;
    int          hits, hit_at;
    logic        any_v;

    vecs[0] = '{8'hCC, 8'hCC, 8'h33};
    vecs[1] = '{8'h03, 8'h03, 8'hC0};
    vecs[2] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[3] = '{8'h96, 8'h96, 8'h69};
    vecs[4] = '{8'h01, 8'h01, 8'h80};
    vecs[5] = '{8'hF0, 8'hF0, 8'h0F};

    // Reset state
    up_valid = 1'b1;
    up_data  = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_m", 32'(m_if.down_valid), 32'd0);
    chk("rst_ready_m", 32'(m_if.up_ready), 32'd0);
    chk("rst_bit_m", 32'(m_if.down_bit), 32'd0);
    chk("rst_last_m", 32'(m_if.down_last), 32'd0);
    chk("rst_busy_m", 32'(m_if.busy), 32'd0);
    chk("rst_bit_l", 32'(l_if.down_bit), 32'd1);
    up_valid = 1'b0;
    rst      = 1'b0;

    // Table of isolated words
    for (int k = 0; k < 6; k++) run_word(vecs[k]);

    // Back-to-back A5, 3C
    run_pair(8'hA5, 8'h3C, -1, bits, lasts, rdys, vals);
    chk("b2b_bits", 32'(bits), 32'h0000_A53C);
    chk("b2b_last", 32'(lasts), 32'h0000_0101);
    chk("b2b_ready", 32'(rdys), 32'h0000_0101);
    chk("b2b_valid", 32'(vals), 32'h0000_FFFF);

    // FF offered three bits into 0F: held until the last-bit cycle
    run_pair(8'h0F, 8'hFF, 2, bits, lasts, rdys, vals);
    chk("hold_bits", 32'(bits), 32'h0000_0FFF);
    chk("hold_last", 32'(lasts), 32'h0000_0101);
    chk("hold_ready", 32'(rdys), 32'h0000_0101);
    chk("hold_valid", 32'(vals), 32'h0000_FFFF);

    // Reset after three bits of F0
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = 8'hF0;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_bit", 32'(m_if.down_bit), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valid_m", 32'(m_if.down_valid), 32'd0);
    chk("rstmid_ready_m", 32'(m_if.up_ready), 32'd0);
    chk("rstmid_bit_m", 32'(m_if.down_bit), 32'd0);
    chk("rstmid_last_m", 32'(m_if.down_last), 32'd0);
    chk("rstmid_valid_l", 32'(l_if.down_valid), 32'd0);
    chk("rstmid_bit_l", 32'(l_if.down_bit), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_ready_after", 32'(m_if.up_ready), 32'd1);
    any_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      any_v = any_v | m_if.down_valid | l_if.down_valid | m_if.down_bit;
    end
    chk("rstmid_no_residue", 32'(any_v), 32'd0);

    // 33, 00 into a 6-bit "110011" detector model
    run_pair(8'h33, 8'h00, -1, bits, lasts, rdys, vals);
    chk("chain_bits", 32'(bits), 32'h0000_3300);
    win    = 6'd0;
    hits   = 0;
    hit_at = -1;
    for (int i = 0; i < 16; i++) begin
      win = {win[4:0], bits[15-i]};
      if (i >= 5 && win == 6'b110011) begin
        hits++;
        hit_at = i;
      end
    end
    chk("chain_hits", 32'(hits), 32'd1);
    chk("chain_hit_pos", 32'(hit_at), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
